// File: rtl/sseg_scan_if.sv
// sseg_scan_if
//   Bundles the value handshake and the display-side outputs of sseg_scan.
//   pts_in/load : new value set {b3,b2,b1,b0} and its valid strobe (driven by master)
//   ready       : scan controller can accept a new value set
//   sel         : active-low digit select to sseg_mux (1111 while blanked)
//   b0..b3      : committed shadow values feeding the mux data inputs
//   frame_tick  : one-cycle pulse in the first cycle of each refresh frame
interface sseg_scan_if;
    logic [11:0] pts_in;
    logic        load;
    logic        ready;
    logic [3:0]  sel;
    logic [2:0]  b0;
    logic [2:0]  b1;
    logic [2:0]  b2;
    logic [2:0]  b3;
    logic        frame_tick;

    modport master (
        output pts_in, load,
        input  ready, sel, b0, b1, b2, b3, frame_tick
    );

    modport slave (
        input  pts_in, load,
        output ready, sel, b0, b1, b2, b3, frame_tick
    );
endinterface

// File: rtl/sseg_scan.sv
// sseg_scan
//   Scan controller for a four-digit seven-segment display. Cycles digits
//   0..3, one slot of DIV clocks each, with the first BLANK clocks of every
//   slot blanked to avoid ghosting. Display values are double-buffered: a
//   value set accepted over the load/ready handshake waits in a pending
//   register and is copied into the shadow registers only on a frame
//   boundary, so a frame never mixes old and new values.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : synchronous active-low reset
//     bus   : sseg_scan_if.slave (pts_in, load, ready, sel, b0..b3, frame_tick)
//   Parameters:
//     DIV   : clock cycles per digit slot (>= 2)
//     BLANK : blanked cycles at the start of each slot (0 <= BLANK < DIV)
module sseg_scan #(
    parameter int DIV   = 100000,
    parameter int BLANK = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    sseg_scan_if.slave bus
);
    localparam int            CW       = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    digit, digit_nx;
    logic          pend, pend_nx;
    logic [11:0]   pend_data;
    logic [11:0]   shadow, shadow_nx;
    logic [3:0]    sel_q, sel_nx;
    logic          tick_q;
    logic          at_boundary;
    logic          capture;
    logic          blank_nx;

    // Counters and handshake. A commit and a capture are mutually exclusive:
    // capture needs pend = 0 while commit needs pend = 1, so pend is never
    // set and cleared on the same edge, and a load accepted on the boundary
    // edge waits for the following boundary.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        cnt_nx      = cnt + 1'b1;
        digit_nx    = digit;
        pend_nx     = pend;
        shadow_nx   = shadow;
        capture     = 1'b0;
        at_boundary = (cnt == CNT_LAST) && (digit == 2'd3);

        if (cnt == CNT_LAST) begin
            cnt_nx   = '0;
            digit_nx = digit + 2'd1;
        end

        if (at_boundary && pend) begin
            shadow_nx = pend_data;
            pend_nx   = 1'b0;
        end else if (bus.load && !pend) begin
            capture = 1'b1;
            pend_nx = 1'b1;
        end
    end

    // Blanking is decoded from the next counter value so the registered sel
    // lines up with the cnt/digit pair of the same cycle.
    generate
        if (BLANK == 0) begin : g_no_blank
            assign blank_nx = 1'b0;
        end else begin : g_blank
            localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
            assign blank_nx = (cnt_nx < BLANK_C);
        end
    endgenerate

    always_comb begin
        sel_nx = blank_nx ? 4'b1111 : ~(4'b0001 << digit_nx);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            cnt    <= '0;
            digit  <= 2'd0;
            pend   <= 1'b0;
            shadow <= 12'd0;
            sel_q  <= 4'b1111;
            tick_q <= 1'b0;
        end else begin
            cnt    <= cnt_nx;
            digit  <= digit_nx;
            pend   <= pend_nx;
            shadow <= shadow_nx;
            sel_q  <= sel_nx;
            tick_q <= at_boundary;
        end
    end

    // NOTE: the pending data register has no reset; it is only observable
    // through pend, which reset clears, so stale contents are never committed.
    always_ff @(posedge clk) begin
        if (capture) begin
            pend_data <= bus.pts_in;
        end
    end

    assign bus.ready      = ~pend;
    assign bus.sel        = sel_q;
    assign bus.frame_tick = tick_q;
    assign bus.b0         = shadow[2:0];
    assign bus.b1         = shadow[5:3];
    assign bus.b2         = shadow[8:6];
    assign bus.b3         = shadow[11:9];
endmodule

// File: tb/tb_sseg_scan.sv
// tb_sseg_scan
//   Self-checking bench for sseg_scan with DIV=8. Two instances share clock,
//   reset and stimulus: one with BLANK=2, one with BLANK=0. A reference model
//   keyed on the cycle number since reset predicts sel, frame_tick, ready and
//   the shadow values; stimulus mixes directed load timings with random loads.
module tb_sseg_scan;
    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = 4 * DIV;

    logic clk;
    logic rst_n;

    sseg_scan_if bus();
    sseg_scan_if bus0();

    sseg_scan #(.DIV(DIV), .BLANK(BLK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    sseg_scan #(.DIV(DIV), .BLANK(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_fail = 0;
    int n;

    // Reference model state
    logic        m_pend;
    logic [11:0] m_pdata;
    logic [11:0] m_shadow;
    int          m_commit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, n, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [3:0] exp_sel(input int cyc, input int blank);
        logic [3:0] one_hot;
        int slot;
        int d;
        slot = cyc % DIV;
        d    = (cyc / DIV) % 4;
        if (cyc == 0) return 4'b1111;        // reset value before first edge
        if (slot < blank) return 4'b1111;
        one_hot = 4'b0001 << d;
        return ~one_hot;
    endfunction

    task automatic model_reset();
        n        = 0;
        m_pend   = 1'b0;
        m_pdata  = 12'd0;
        m_shadow = 12'd0;
        m_commit = 0;
    endtask

    task automatic drive(input logic ld, input logic [11:0] d);
        bus.load    = ld;
        bus.pts_in  = d;
        bus0.load   = ld;
        bus0.pts_in = d;
    endtask

    task automatic do_reset();
        drive(1'b0, 12'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_outputs();
        logic exp_tick;
        if (m_pend && n == m_commit) begin
            m_shadow = m_pdata;
            m_pend   = 1'b0;
        end
        exp_tick = (n > 0) && (n % FRAME == 0);
        check("sel",         32'(bus.sel),         32'(exp_sel(n, BLK)));
        check("sel_blank0",  32'(bus0.sel),        32'(exp_sel(n, 0)));
        check("frame_tick",  32'(bus.frame_tick),  32'(exp_tick));
        check("frame_tick0", 32'(bus0.frame_tick), 32'(exp_tick));
        check("ready",       32'(bus.ready),       32'(!m_pend));
        check("ready0",      32'(bus0.ready),      32'(!m_pend));
        check("shadow",  32'({bus.b3, bus.b2, bus.b1, bus.b0}),     32'(m_shadow));
        check("shadow0", 32'({bus0.b3, bus0.b2, bus0.b1, bus0.b0}), 32'(m_shadow));
    endtask

    // Accept rule: the commit lands on the first frame start at least two
    // cycles after the accepting cycle (strictly after the accepting edge).
    task automatic model_load(input logic ld, input logic [11:0] d);
        if (ld && !m_pend) begin
            m_pend   = 1'b1;
            m_pdata  = d;
            m_commit = ((n + 2 + FRAME - 1) / FRAME) * FRAME;
        end
    endtask

    // mode 0 free run, 1 load@5 + ignored load@10, 2 load@31, 3 load@30,
    // 4 random loads, 5 load@5 then reset during cycle 20
    task automatic run_seg(input int mode, input int ncyc);
        logic [11:0] first;
        logic [11:0] d;
        logic        ld;
        logic        did_rst;
        did_rst = 1'b0;
        first   = 12'b101_100_011_010;
        do_reset();
        while (n < ncyc) begin
            check_outputs();
            if (mode == 1 && n == 32) begin
                check("b0_dir", 32'(bus.b0), 32'(3'b010));
                check("b3_dir", 32'(bus.b3), 32'(3'b101));
            end
            if (mode == 2 && n == 32) check("late_b", 32'(bus.b0), 32'(3'b000));
            if (mode == 5 && n == 20 && !did_rst) begin
                did_rst = 1'b1;
                drive(1'b0, 12'd0);
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                model_reset();
                check("rst_cnt",   32'(dut.cnt),   32'd0);
                check("rst_digit", 32'(dut.digit), 32'd0);
                continue;
            end
            ld = 1'b0;
            d  = 12'($urandom);
            case (mode)
                1: begin
                    if (n == 5) begin ld = 1'b1; d = first; end
                    if (n == 10) begin
                        ld = 1'b1;
                        if (d == first) d = ~first;
                    end
                end
                2: if (n == 31) begin ld = 1'b1; d = first; end
                3: if (n == 30) begin ld = 1'b1; d = first; end
                4: ld = ($urandom_range(0, 5) == 0);
                5: if (n == 5 && !did_rst) begin ld = 1'b1; d = first; end
                default: ld = 1'b0;
            endcase
            drive(ld, d);
            model_load(ld, d);
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        drive(1'b0, 12'd0);
        run_seg(0, 70);
        run_seg(1, 70);
        run_seg(2, 70);
        run_seg(3, 70);
        run_seg(4, 400);
        run_seg(5, 70);
        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end
endmodule
